// File: rtl/binary_search_ctrl_if.sv
// Request/RAM/result bundle between the search controller and its neighbours.
// The slave modport is the controller; the master modport is the surrounding logic.
interface binary_search_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [DATA_W-1:0] target;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] result_addr;
  logic              hex_hide;

  modport slave (
    input  start, target, mem_rdata,
    output mem_addr, busy, done, found, result_addr, hex_hide
  );

  modport master (
    output start, target, mem_rdata,
    input  mem_addr, busy, done, found, result_addr, hex_hide
  );
endinterface

// File: rtl/binary_search_ctrl.sv
// Binary search over a sorted synchronous RAM; three clocks per probe
// (issue address, RAM latency, compare). Result feeds the hex display stage.
module binary_search_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  binary_search_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] tgt;
  // One extra bit so mid+1 past the top and mid-1 below zero stay out of range.
  logic [ADDR_W:0]   lo, hi;
  logic [ADDR_W:0]   sum, mid_ext, mid_p1, mid_m1;
  logic [ADDR_W-1:0] mid;

  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] TOP_IDX = {1'b0, {ADDR_W{1'b1}}};

  assign sum     = lo + hi;
  assign mid     = sum[ADDR_W:1];
  assign mid_ext = {1'b0, mid};
  assign mid_p1  = mid_ext + ONE;
  assign mid_m1  = mid_ext - ONE;

  assign bus.hex_hide = ~(bus.done & bus.found);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      tgt             <= '0;
      lo              <= '0;
      hi              <= '0;
      bus.mem_addr    <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.found       <= 1'b0;
      bus.result_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            tgt      <= bus.target;
            lo       <= '0;
            hi       <= TOP_IDX;
            bus.busy <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_addr <= mid;
          state        <= WAIT;
        end
        WAIT: state <= CMP;
        CMP: begin
          if (bus.mem_rdata == tgt) begin
            bus.result_addr <= mid;
            bus.found       <= 1'b1;
            bus.done        <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= DONE;
          end else if (bus.mem_rdata < tgt) begin
            lo <= mid_p1;
            if (mid_p1 > hi) begin
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state    <= DONE;
            end else begin
              state <= ISSUE;
            end
          end else begin
            hi <= mid_m1;
            // lo > mid-1 is lo >= mid; avoids relying on the decremented value.
            if (lo >= mid_ext) begin
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state    <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          if (!bus.start) begin
            bus.done        <= 1'b0;
            bus.found       <= 1'b0;
            bus.result_addr <= '0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
